uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
UART transmitter that serializes parallel bytes into asynchronous frames. Frame format: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1). It is the transmit-side counterpart of the UART_RX receiver and uses the same frame format and parity options. It runs on the TX bit clock, so each serial bit lasts exactly one CLK cycle. Upstream is the system-side data source (e.g. an async FIFO read port); downstream is the TX pin.

Parameters:
DATA_WIDTH, 8, payload bits per frame; bit counter width is clog2(DATA_WIDTH).

Ports:
CLK  input  1  TX bit clock; one serial bit per cycle.
RST  input  1  Synchronous reset, active-high.
P_DATA  input  DATA_WIDTH  Parallel byte; sampled only on the accept cycle.
DATA_VALID  input  1  Request to send P_DATA.
PAR_EN  input  1  1 inserts a parity bit; sampled only on the accept cycle.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled only on the accept cycle.
TX_OUT  output  1  Serial line, registered; idles high.
busy  output  1  Registered; 1 whenever a frame bit is on TX_OUT.

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: state=IDLE, TX_OUT=1, busy=0, shift register=0, bit counter=0, latched parity config=0. Reset wins over every other condition, including mid-frame: the next edge forces the line high with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP.
- ready (internal) = (state==IDLE) || (state==STOP).
- Accept: DATA_VALID && ready at a rising edge.
  - On that edge, latch P_DATA, PAR_EN and PAR_TYP.
  - Compute the parity bit: ^P_DATA for even, ~^P_DATA for odd.
  - Go to START.
  - DATA_VALID while not ready is ignored and not queued; the source must hold it until busy is low or the STOP bit is on the line.
- TX_OUT and busy are registered at the same edge as the state, so the bit for state S is on TX_OUT during the cycle state==S.
  - START: TX_OUT=0 for 1 cycle, bit counter cleared; then go to DATA.
  - DATA: TX_OUT=shift[0], shift right each cycle, counter increments.
    - Stay DATA_WIDTH cycles.
    - At count DATA_WIDTH-1, go to PARITY if the latched PAR_EN is 1, else STOP.
  - PARITY: TX_OUT=latched parity bit for 1 cycle; then go to STOP.
  - STOP: TX_OUT=1 for 1 cycle.
    - Next state is START if an accept occurs this cycle (back-to-back, zero idle gap).
    - Otherwise next state is IDLE.
  - IDLE: TX_OUT=1, busy=0.
- busy=1 in START, DATA, PARITY and STOP.
  - busy drops the cycle after STOP unless a back-to-back frame was accepted.
- Latency: accept edge to first start-bit cycle = 1 cycle.
- Frame length: 10 cycles (DATA_WIDTH=8, no parity) or 11 cycles (with parity).
- Config stability: PAR_EN, PAR_TYP and P_DATA changes mid-frame have no effect on the current frame; they apply only at the next accept.
- DATA_VALID held continuously produces continuous back-to-back frames. P_DATA is resampled at each STOP-cycle accept.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP);
  - PAR_EVEN=0 and PAR_ODD=1;
  - bit constants START_BIT=0 and STOP_BIT=1.
  These are shared with UART_RX.
- Sub-module uart_tx_serializer: shift register plus bit counter, with load, shift and done outputs.
- The FSM, parity computation and output mux stay in uart_tx_frame.

Test Plan:
- Reset then idle 5 cycles -> TX_OUT=1, busy=0 throughout.
- P_DATA=0xA5, PAR_EN=0, 1-cycle DATA_VALID from IDLE -> TX_OUT=0,1,0,1,0,0,1,0,1,1 over 10 cycles starting 1 cycle after accept; busy high exactly those 10 cycles.
- P_DATA=0xA5, PAR_EN=1 -> parity bit 0 with PAR_TYP=0 and 1 with PAR_TYP=1, in cycle 10 of an 11-cycle frame; stop bit=1.
- Back-to-back: 0x0F accepted, then DATA_VALID with P_DATA=0xF0 during its STOP cycle -> next cycle is start bit 0, no idle gap; second frame data bits 0,0,0,0,1,1,1,1.
- DATA_VALID pulsed with 0x3C during the DATA bits of a frame -> ignored; no extra frame follows. Toggling PAR_EN mid-frame leaves the current frame length unchanged.
- RST asserted at data bit 4 -> next cycle TX_OUT=1, busy=0, state IDLE. A new accept after reset produces a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: frame-format constants and state encoding shared by the UART transmitter and receiver.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: byte-source handshake, parity config and serial line of the UART transmitter.
interface uart_tx_frame_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  busy;
   modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, input TX_OUT, busy);
   modport slave (input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, output TX_OUT, busy);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: LSB-first shift register with a data-bit counter for the UART transmitter.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift,
   input  logic                  count,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  bit_out,
   output logic                  done
);
   localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   always_comb begin
      shift_d = load ? load_data : shift ? shift_q >> 1 : shift_q;
      cnt_d   = load ? '0 : count ? cnt_q + CW'(1) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end
   assign bit_out = shift_q[0];
   assign done    = cnt_q == CW'(DATA_WIDTH - 1);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter producing start, LSB-first data, optional parity and stop bits,
// one bit per clock, with back-to-back frames accepted during the stop bit.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input logic            CLK,
   input logic            RST,
   uart_tx_frame_if.slave bus
);
   uart_state_e state_q, state_d;
   logic tx_q, tx_d, busy_q, busy_d;
   logic par_en_q, par_en_d, par_bit_q, par_bit_d;
   logic accept, ser_bit, ser_done;
   assign accept = bus.DATA_VALID && (state_q == IDLE || state_q == STOP);
   // The register is shifted while START is on the line, so shift[0] always holds the next data bit.
   uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
      .clk       (CLK),
      .rst       (RST),
      .load      (accept),
      .shift     (state_q == START || state_q == DATA),
      .count     (state_q == DATA),
      .load_data (bus.P_DATA),
      .bit_out   (ser_bit),
      .done      (ser_done)
   );
   always_comb begin
      case (state_q)
         IDLE, STOP: state_d = accept ? START : IDLE;
         START:      state_d = DATA;
         DATA:       state_d = ser_done ? (par_en_q ? PARITY : STOP) : DATA;
         PARITY:     state_d = STOP;
         default:    state_d = IDLE;
      endcase
      par_en_d  = accept ? bus.PAR_EN : par_en_q;
      par_bit_d = accept ? (bus.PAR_TYP == PAR_ODD ? ~^bus.P_DATA : ^bus.P_DATA) : par_bit_q;
      tx_d      = state_d == START  ? START_BIT :
                  state_d == DATA   ? ser_bit   :
                  state_d == PARITY ? par_bit_q : STOP_BIT;
      busy_d    = state_d != IDLE;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
      end
   end
   assign bus.TX_OUT = tx_q;
   assign bus.busy   = busy_q;
endmodule
